// File: rtl/ysyx_20020207_lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, byte-lane masks, FSM states.
package ysyx_20020207_lsu_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/ysyx_20020207_lsu_if.sv
// Data memory request/response bus between the LSU (master) and the memory port (slave).
interface ysyx_20020207_lsu_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/ysyx_20020207_lsu_align.sv
// Byte-lane logic: store mask/replication and legality on the incoming access,
// load lane select and extension on the latched access.
module ysyx_20020207_lsu_align
    import ysyx_20020207_lsu_pkg::*;
(
    input  logic [1:0]            st_off,
    input  logic [2:0]            st_op,
    input  logic                  is_store,
    input  logic [LSU_DATA_W-1:0] st_data,
    input  logic [1:0]            ld_off,
    input  logic [2:0]            ld_op,
    input  logic [LSU_DATA_W-1:0] ld_word,
    output logic [3:0]            wmask_c,
    output logic [LSU_DATA_W-1:0] wdata_c,
    output logic [LSU_DATA_W-1:0] ldata_c,
    output logic                  illegal_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store lane mask and data replication so any enabled lane carries the right bytes
    always_comb begin
        wmask_c = 4'b0000;
        wdata_c = st_data;
        case (st_op)
            LSU_B, LSU_BU: begin
                wmask_c = MASK_B << st_off;
                wdata_c = {4{st_data[7:0]}};
            end
            LSU_H, LSU_HU: begin
                wmask_c = MASK_H << {st_off[1], 1'b0};
                wdata_c = {2{st_data[15:0]}};
            end
            LSU_W:   wmask_c = MASK_W;
            default: wmask_c = 4'b0000;
        endcase
    end

    // Misalignment, reserved funct3 and unsigned store encodings are all rejected
    always_comb begin
        illegal_c = 1'b0;
        case (st_op)
            LSU_B:   illegal_c = 1'b0;
            LSU_BU:  illegal_c = is_store;
            LSU_H:   illegal_c = st_off[0];
            LSU_HU:  illegal_c = st_off[0] | is_store;
            LSU_W:   illegal_c = |st_off;
            default: illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = 8'(ld_word >> {ld_off, 3'b000});
        half_sel = 16'(ld_word >> {ld_off[1], 4'b0000});
        ldata_c  = ld_word;
        case (ld_op)
            LSU_B:   ldata_c = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  ldata_c = {24'b0, byte_sel};
            LSU_H:   ldata_c = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  ldata_c = {16'b0, half_sel};
            default: ldata_c = ld_word;
        endcase
    end

endmodule

// File: rtl/ysyx_20020207_lsu.sv
// Load/store unit: accepts one ALU address pulse, runs one word-aligned memory
// transaction and returns an extended load result with a one-cycle completion pulse.
module ysyx_20020207_lsu
    import ysyx_20020207_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               addr_valid,
    input  logic [ADDR_W-1:0]  lsu_addr,
    input  logic [DATA_W-1:0]  lsu_wdata,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [2:0]         lsu_op,
    ysyx_20020207_lsu_if.master mem,
    output logic [DATA_W-1:0]  lsu_rdata,
    output logic               lsu_valid,
    output logic               lsu_err,
    output logic               lsu_busy
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;
    logic              accept_c;
    logic [2:0]        op_q;
    logic [1:0]        off_q;
    logic [3:0]        wmask_c;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] ldata_c;
    logic              illegal_c;

    ysyx_20020207_lsu_align u_align (
        .st_off    (lsu_addr[1:0]),
        .st_op     (lsu_op),
        .is_store  (lsu_wen),
        .st_data   (lsu_wdata),
        .ld_off    (off_q),
        .ld_op     (op_q),
        .ld_word   (mem.mem_rdata),
        .wmask_c   (wmask_c),
        .wdata_c   (wdata_c),
        .ldata_c   (ldata_c),
        .illegal_c (illegal_c)
    );

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (addr_valid && (lsu_ren || lsu_wen)) begin
                    accept_c = 1'b1;
                    state_d  = illegal_c ? DONE : REQ;
                end
            end
            REQ:     if (mem.mem_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are captured once at accept so they stay stable until mem_ready
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= 3'b000;
            off_q         <= 2'b00;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_wmask <= 4'b0000;
            lsu_rdata     <= '0;
            lsu_valid     <= 1'b0;
            lsu_err       <= 1'b0;
            lsu_busy      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem.mem_req <= (state_d == REQ);
            lsu_valid   <= (state_d == DONE);
            lsu_busy    <= (state_d != IDLE);
            if (accept_c && !illegal_c) begin
                mem.mem_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
                mem.mem_we    <= lsu_wen;
                mem.mem_wmask <= lsu_wen ? wmask_c : 4'b0000;
                mem.mem_wdata <= lsu_wen ? wdata_c : '0;
                op_q          <= lsu_op;
                off_q         <= lsu_addr[1:0];
            end
            if (accept_c && illegal_c) begin
                lsu_err   <= 1'b1;
                lsu_rdata <= '0;
            end else if (state_q == REQ && mem.mem_ready) begin
                lsu_err       <= 1'b0;
                lsu_rdata     <= mem.mem_we ? '0 : ldata_c;
                mem.mem_we    <= 1'b0;
                mem.mem_wmask <= 4'b0000;
            end else if (state_q == DONE) begin
                lsu_err <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // A new address while a transaction is outstanding is dropped by the FSM
    always @(posedge clock) begin
        if (!reset && addr_valid) assert (state_q == IDLE);
    end
`endif

endmodule

// File: tb/tb_ysyx_20020207_lsu.sv
// Scoreboard bench: driver pushes expected bus/result records, a bus responder and a
// completion monitor pop and compare independently.
module tb_ysyx_20020207_lsu;
    import ysyx_20020207_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        addr_valid;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_ren;
    logic        lsu_wen;
    logic [2:0]  lsu_op;
    logic [31:0] lsu_rdata;
    logic        lsu_valid;
    logic        lsu_err;
    logic        lsu_busy;

    ysyx_20020207_lsu_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    ysyx_20020207_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .addr_valid (addr_valid),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_ren    (lsu_ren),
        .lsu_wen    (lsu_wen),
        .lsu_op     (lsu_op),
        .mem        (mem_bus),
        .lsu_rdata  (lsu_rdata),
        .lsu_valid  (lsu_valid),
        .lsu_err    (lsu_err),
        .lsu_busy   (lsu_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic stray_ready = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: derive expectations from access size, signedness and offset
    task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic r, input logic w,
                        input logic [2:0] op, input logic [31:0] rd, input int d);
        res_t e;
        bus_t b;
        int sz, nb, off;
        bit st, ill;
        logic [63:0] v, lm;
        @(posedge clock); #1;
        addr_valid = 1'b1;
        lsu_addr   = a;
        lsu_wdata  = wd;
        lsu_ren    = r;
        lsu_wen    = w;
        lsu_op     = op;
        if (r || w) begin
            st  = w;
            sz  = int'(op[1:0]);
            off = int'(a[1:0]);
            ill = (sz == 3) || (op[2] && op[1]) || (st && op[2]) || ((off % (1 << sz)) != 0);
            nb  = 1 << sz;
            e.err   = ill;
            e.cyc   = cyc + (ill ? 1 : 2 + d);
            e.rdata = 32'h0;
            if (!ill) begin
                b.addr  = {a[31:2], 2'b00};
                b.we    = st;
                b.rdata = rd;
                b.delay = d;
                b.wmask = 4'h0;
                b.wdata = 32'h0;
                if (st) begin
                    b.wmask = 4'(((1 << nb) - 1) << off);
                    for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
                end else begin
                    lm = (64'd1 << (8 * nb)) - 64'd1;
                    v  = (64'(rd) >> (8 * off)) & lm;
                    if (!op[2] && v[8*nb-1]) v = v | ~lm;
                    e.rdata = 32'(v);
                end
                bus_q.push_back(b);
            end
            res_q.push_back(e);
        end
        @(posedge clock); #1;
        addr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((lsu_busy || res_q.size() != 0 || bus_q.size() != 0) && n < 40);
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL timeout: busy %b pending %0d expected idle", lsu_busy, res_q.size());
        end
    endtask

    // Memory responder: checks held request fields, answers after the chosen delay
    initial begin : responder
        bus_t cur;
        bit   active;
        int   cnt;
        active = 1'b0;
        cnt    = 0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            mem_bus.mem_ready = stray_ready;
            mem_bus.mem_rdata = $urandom;
            if (reset) begin
                active = 1'b0;
                bus_q.delete();
            end else if (mem_bus.mem_req) begin
                if (!active) begin
                    if (bus_q.size() == 0) check("unexpected_req", 32'(mem_bus.mem_req), 32'h0);
                    else begin
                        cur    = bus_q.pop_front();
                        active = 1'b1;
                        cnt    = 0;
                    end
                end
                if (active) begin
                    check("mem_addr", mem_bus.mem_addr, cur.addr);
                    check("mem_we", 32'(mem_bus.mem_we), 32'(cur.we));
                    check("mem_wmask", 32'(mem_bus.mem_wmask), 32'(cur.wmask));
                    if (cur.we) check("mem_wdata", mem_bus.mem_wdata, cur.wdata);
                    if (cnt == cur.delay) begin
                        mem_bus.mem_ready = 1'b1;
                        mem_bus.mem_rdata = cur.rdata;
                        active = 1'b0;
                    end else begin
                        cnt++;
                    end
                end
            end
            if (!mem_bus.mem_we) check("wmask_no_write", 32'(mem_bus.mem_wmask), 32'h0);
        end
    end

    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clock);
            if (!reset && lsu_valid) begin
                if (res_q.size() == 0) check("unexpected_valid", 32'(lsu_valid), 32'h0);
                else begin
                    e = res_q.pop_front();
                    check("lsu_rdata", lsu_rdata, e.rdata);
                    check("lsu_err", 32'(lsu_err), 32'(e.err));
                    check("latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (lsu_err) begin
                check("err_without_valid", 32'(lsu_err), 32'h0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] a;
        logic [1:0]  rw;
        reset      = 1'b1;
        addr_valid = 1'b0;
        lsu_addr   = 32'h0;
        lsu_wdata  = 32'h0;
        lsu_ren    = 1'b0;
        lsu_wen    = 1'b0;
        lsu_op     = 3'b000;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_bus.mem_we), 32'h0);
        check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
        check("rst_lsu_valid", 32'(lsu_valid), 32'h0);
        check("rst_lsu_busy", 32'(lsu_busy), 32'h0);
        check("rst_lsu_rdata", lsu_rdata, 32'h0);

        send(32'h8000_0003, 32'h0000_00AB, 1'b0, 1'b1, LSU_B, 32'h0, 0);  wait_idle();
        send(32'h8000_0002, 32'h0, 1'b1, 1'b0, LSU_H, 32'h8765_4321, 0);  wait_idle();
        send(32'h8000_0002, 32'h0, 1'b1, 1'b0, LSU_HU, 32'h8765_4321, 1); wait_idle();
        send(32'h8000_0001, 32'h0, 1'b1, 1'b0, LSU_B, 32'h8765_4321, 0);  wait_idle();
        send(32'h8000_0004, 32'h0, 1'b1, 1'b0, LSU_W, 32'hDEAD_BEEF, 3);  wait_idle();
        send(32'h8000_0001, 32'h0, 1'b1, 1'b0, LSU_W, 32'h0, 0);          wait_idle();
        send(32'h8000_0003, 32'h1234_5678, 1'b0, 1'b1, LSU_H, 32'h0, 0);  wait_idle();
        send(32'h8000_0000, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 0);         wait_idle();
        send(32'h8000_0000, 32'h55, 1'b1, 1'b1, LSU_BU, 32'h0, 0);        wait_idle();

        send(32'h8000_0008, 32'h0, 1'b0, 1'b0, LSU_W, 32'h0, 0);
        repeat (3) begin
            @(negedge clock);
            check("noop_busy", 32'(lsu_busy), 32'h0);
            check("noop_req", 32'(mem_bus.mem_req), 32'h0);
        end

        // Reset while the request is outstanding, then a stray ready
        send(32'h8000_0010, 32'h0, 1'b1, 1'b0, LSU_W, 32'h1234_5678, 10);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        res_q.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rreq_mem_req", 32'(mem_bus.mem_req), 32'h0);
        check("rreq_busy", 32'(lsu_busy), 32'h0);
        @(posedge clock); #1 stray_ready = 1'b1;
        @(posedge clock); #1 stray_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("stray_valid", 32'(lsu_valid), 32'h0);
            check("stray_busy", 32'(lsu_busy), 32'h0);
        end
        send(32'h8000_0020, 32'hCAFE_F00D, 1'b0, 1'b1, LSU_W, 32'h0, 1);  wait_idle();

        for (int k = 0; k < 80; k++) begin
            rw = 2'($urandom_range(0, 3));
            a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            send(a, $urandom, rw[0], rw[1], 3'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 3)));
            wait_idle();
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
